inst_fetch_ctrl: RTL and testbench

//  Instruction fetch sequencer for the 48-bit combinational instruction memory (32 words).

---
 rtl/inst_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the combinational
// instruction memory, buffers fetched words in a small prefetch FIFO and
// hands them to decode over a valid/ready handshake. Supports branch
// redirect and stops fetching on a halt word.
module inst_fetch_ctrl #(
   parameter int                 DATA_W     = 48,
   parameter int                 ADDR_W     = 5,
   parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
   parameter int                 FIFO_DEPTH = 2,
   parameter logic [DATA_W-1:0]  HALT_WORD  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              busy,
   output logic              halted
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic [DATA_W-1:0] data_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] pc_q   [FIFO_DEPTH];

   logic pop;
   logic full;
   logic redirect;
   logic fetch_en;
   logic is_halt;
   logic push;

   // Handshake and fetch qualification. A fetch is allowed into a full FIFO
   // when the head leaves in the same cycle, which keeps 1 word/cycle.
   assign inst_valid = (count != '0);
   assign pop        = inst_valid && inst_ready;
   assign full       = (count == FULL_CNT);
   assign redirect   = br_valid && (state != IDLE);
   assign fetch_en   = (state == FETCH) && !br_valid && (!full || pop);
   assign is_halt    = (mem_data == HALT_WORD);
   assign push       = fetch_en && !is_halt;

   assign mem_addr = {{(DATA_W-ADDR_W){1'b0}}, pc};

   // FIFO head is presented from storage registers; forced to zero when
   // empty so the outputs read as zero after reset or a flush.
   assign inst_data = inst_valid ? data_q[rd_ptr] : '0;
   assign inst_pc   = inst_valid ? pc_q[rd_ptr]   : '0;

   assign busy   = (state == FETCH);
   assign halted = (state == HALT) && !inst_valid;

   // Sequencer state, PC and FIFO bookkeeping; redirect wins over everything
   // and empties the FIFO (a simultaneous pop has already been consumed).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect) begin
         state  <= FETCH;
         pc     <= br_target;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            state <= FETCH;
         end
         if (fetch_en) begin
            if (is_halt) begin
               state <= HALT;
            end else begin
               pc <= pc + ADDR_W'(1);
            end
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO payload storage; written only on a push, never reset since the
   // occupancy count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr] <= mem_data;
         pc_q[wr_ptr]   <= pc;
      end
   end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model with
// a scoreboard of expected instructions drained by a separate monitor.
module tb_inst_fetch_ctrl;

   localparam int DW    = 48;
   localparam int AW    = 5;
   localparam int DEPTH = 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          br_valid;
   logic [AW-1:0] br_target;
   logic          inst_valid;
   logic          inst_ready;
   logic [DW-1:0] inst_data;
   logic [AW-1:0] inst_pc;
   logic          busy;
   logic          halted;

   logic [DW-1:0] mem [32];

   typedef struct packed {
      logic [DW-1:0] d;
      logic [AW-1:0] p;
   } ent_t;

   // Reference model state (value before the next rising edge)
   int            m_mode;   // 0 idle, 1 fetching, 2 halted
   int            m_pc;
   ent_t          m_q [$];
   ent_t          sb_q [$];

   int checks;
   int errors;

   inst_fetch_ctrl #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .RESET_PC  ('0),
      .FIFO_DEPTH(DEPTH),
      .HALT_WORD ('0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .br_valid  (br_valid),
      .br_target (br_target),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst_data (inst_data),
      .inst_pc   (inst_pc),
      .busy      (busy),
      .halted    (halted)
   );

   assign mem_data = mem[mem_addr[AW-1:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      if (r[DW-1:0] == '0) r[0] = 1'b1;
      return r[DW-1:0];
   endfunction

   task automatic fill_mem(input int zero_odds);
      for (int i = 0; i < 32; i++) begin
         if (zero_odds > 0 && ($urandom % zero_odds) == 0) mem[i] = '0;
         else mem[i] = rand_word();
      end
   endtask

   // Advance the model by one clock edge given the inputs for that edge.
   task automatic model_step(input logic s, input logic b, input logic [AW-1:0] t, input logic r);
      bit do_pop;
      bit room;
      do_pop = (m_q.size() > 0) && r;
      if (do_pop) sb_q.push_back(m_q[0]);
      if (b && m_mode != 0) begin
         m_q.delete();
         m_pc   = int'(t);
         m_mode = 1;
      end else begin
         room = (m_q.size() < DEPTH) || do_pop;
         if (do_pop) void'(m_q.pop_front());
         if (m_mode == 1 && room) begin
            if (mem[m_pc] == '0) begin
               m_mode = 2;
            end else begin
               m_q.push_back('{d: mem[m_pc], p: AW'(m_pc)});
               m_pc = (m_pc + 1) % 32;
            end
         end else if (m_mode == 0 && s) begin
            m_mode = 1;
         end
      end
   endtask

   // One clock cycle: drive inputs, check visible status, step the model.
   task automatic cycle(input logic s, input logic b, input logic [AW-1:0] t, input logic r);
      @(negedge clk);
      start      = s;
      br_valid   = b;
      br_target  = t;
      inst_ready = r;
      #1;
      chk("inst_valid", DW'(inst_valid), DW'(m_q.size() != 0));
      chk("busy",       DW'(busy),       DW'(m_mode == 1));
      chk("halted",     DW'(halted),     DW'(m_mode == 2 && m_q.size() == 0));
      chk("mem_addr",   mem_addr,        DW'(m_pc));
      model_step(s, b, t, r);
   endtask

   task automatic run(input int n, input logic r);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, r);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      @(negedge clk);
      start = 1'b0; br_valid = 1'b0; br_target = '0; inst_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_inst_valid", DW'(inst_valid), '0);
      chk("rst_inst_data",  inst_data,       '0);
      chk("rst_inst_pc",    DW'(inst_pc),    '0);
      chk("rst_busy",       DW'(busy),       '0);
      chk("rst_halted",     DW'(halted),     '0);
      chk("rst_mem_addr",   mem_addr,        '0);
      m_q.delete();
      sb_q.delete();
      m_mode = 0;
      m_pc   = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: whenever decode takes the head, it must match the scoreboard.
   always begin
      ent_t e;
      @(negedge clk);
      #2;
      if (rst_n && inst_valid && inst_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got data %0h pc %0d with nothing expected", inst_data, inst_pc);
         end else begin
            e = sb_q.pop_front();
            chk("inst_data", inst_data, e.d);
            chk("inst_pc", DW'(inst_pc), DW'(e.p));
         end
      end
   end

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; start = 1'b0; br_valid = 1'b0; br_target = '0; inst_ready = 1'b0;
      m_mode = 0; m_pc = 0;
      fill_mem(0);
      #12;
      rst_n = 1'b1;

      // 1: straight-line run to a halt word
      do_reset();
      fill_mem(0);
      mem[4] = '0;
      cycle(1'b1, 1'b0, '0, 1'b1);
      run(9, 1'b1);

      // 2: decode stalls, FIFO fills, then releases
      do_reset();
      cycle(1'b1, 1'b0, '0, 1'b0);
      run(5, 1'b0);
      run(8, 1'b1);

      // 3: redirect while full and popping
      do_reset();
      cycle(1'b1, 1'b0, '0, 1'b0);
      run(4, 1'b0);
      cycle(1'b0, 1'b1, 5'd10, 1'b1);
      run(4, 1'b1);

      // 4: PC wrap from 31 to 0, then halt at mem[4]
      cycle(1'b0, 1'b1, 5'd30, 1'b1);
      run(12, 1'b1);

      // 5: redirect out of HALT
      cycle(1'b0, 1'b1, 5'd14, 1'b1);
      run(5, 1'b1);

      // 6: reset with a full FIFO, then stay idle until start
      run(3, 1'b0);
      do_reset();
      run(3, 1'b1);
      cycle(1'b1, 1'b0, '0, 1'b1);
      run(3, 1'b1);

      // Randomized traffic
      for (int blk = 0; blk < 6; blk++) begin
         do_reset();
         fill_mem(8);
         for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 16) == 0, ($urandom % 12) == 0, AW'($urandom), ($urandom % 4) != 0);
         end
      end

      @(negedge clk);
      #5;
      chk("sb_drained", DW'(sb_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
